vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4: grants lost by a waiting CPU/DMA port before it pre-empts video priority (1..7).
REQ-002 Parameter TIMEOUT, default 255: cycles in ACTIVE without i_bus_ready before abort (1..255).
REQ-003 i_clock  in  1  sole clock; all state on its rising edge.
REQ-004 i_reset_n  in  1  reset is asynchronous and active-low.
REQ-005 i_{v,c,d}_request  in  1 each  level request from video (v), CPU (c), DMA (d); held until that port's ready.
REQ-006 i_{v,c,d}_rw  in  1 each  1 = write, 0 = read.
REQ-007 i_{v,c,d}_address  in  32 each  word address.
REQ-008 i_{v,c,d}_wdata  in  32 each  write data.
REQ-009 o_{v,c,d}_rdata  out  32 each  read data, valid while the port's ready is high.
REQ-010 o_{v,c,d}_ready  out  1 each  one-cycle completion pulse.
REQ-011 o_bus_request, o_bus_rw  out  1 each  downstream request and direction, registered.
REQ-012 o_bus_address, o_bus_wdata  out  32 each  downstream address and data, registered.
REQ-013 i_bus_rdata  in  32  downstream read data.
REQ-014 i_bus_ready  in  1  downstream completion.
REQ-015 o_video_busy  out  1  high while the owner is v or i_v_request is high; drives DMA stall.
REQ-016 o_timeout  out  1  sticky; set on any abort.

Function
REQ-017 FSM states: IDLE, ACTIVE, ACK. IDLE->ACTIVE on any request. ACTIVE->ACK on i_bus_ready or timeout. ACK->IDLE unconditionally.
REQ-018 Winner is selected in IDLE from requests sampled at the clock edge. Default priority: v > round-robin(c,d).
REQ-019 A c or d port whose wait counter >= MAX_WAIT beats v. If both c and d are at the limit, the round-robin pointer decides.
REQ-020 Round-robin pointer toggles to the other of c/d after each c or d grant; it is unchanged by v grants.
REQ-021 Wait counters (3-bit, saturating) increment when another port is granted while their port requests; a counter clears on its own grant.
REQ-022 On the IDLE->ACTIVE edge, o_bus_* load from the winner and o_bus_request=1. o_bus_* are held constant through ACTIVE.
REQ-023 On the ACTIVE->ACK edge, o_bus_request=0. i_bus_rdata latches to the owner's o_rdata. The owner's o_ready=1 for exactly the ACK cycle; other ready outputs stay 0.
REQ-024 Latency: request seen at edge N gives o_bus_request at N+1. i_bus_ready sampled at edge M gives port ready during cycle M+1 and IDLE at M+2. Minimum port-to-port turnaround is 3 cycles.
REQ-025 A request deasserted during ACTIVE is ignored: the transaction completes and the ready pulse still issues.
REQ-026 A timeout counter resets on IDLE->ACTIVE. On reaching TIMEOUT, the FSM enters ACK with o_rdata=32'hDEADBEEF and sets o_timeout.
REQ-027 i_bus_ready seen in IDLE or ACK is ignored.
REQ-028 o_rdata for non-owners holds its last latched value.

Reset
REQ-029 Asynchronous assertion drives IDLE, all o_* to 0, counters to 0, pointer to c, and o_timeout to 0, mid-transaction included.
REQ-030 First arbitration occurs on the first edge after deassertion.

Structure
REQ-031 Package vram_arb_pkg holds the state enum, the owner enum {OWN_V, OWN_C, OWN_D}, and the abort constant 32'hDEADBEEF.
REQ-032 One sub-module, vram_arb_pick: combinational winner select from requests, wait counters, pointer and MAX_WAIT.

Verification
REQ-033 Bench: v, c, d all request at once, downstream ready 2 cycles after request -> grant order v, c, then v held off until d (or c) reaches MAX_WAIT=4 grants; no port starves.
REQ-034 Bench: c and d alternate with v idle -> grants c,d,c,d. With v held high and MAX_WAIT=4 -> c wins after 4 v grants.
REQ-035 Bench: CPU read at address 0x100, downstream returns 0x12345678 with i_bus_ready at edge M -> o_c_ready high only in cycle M+1 with o_c_rdata=0x12345678.
REQ-036 Bench: downstream never readies, TIMEOUT=8 -> ready pulse 9 cycles after o_bus_request, rdata 0xDEADBEEF, o_timeout stays 1.
REQ-037 Bench: i_reset_n low mid-ACTIVE -> o_bus_request=0 immediately. After release, a pending v request is granted on the first edge.
REQ-038 Bench: v requests during a DMA transaction -> o_video_busy=1 from that cycle. The DMA transaction completes before v is granted.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the three-port VRAM arbiter.
// Owner encoding doubles as the index into the per-port packed arrays.
package vram_arb_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_ACK} state_e;
    typedef enum logic [1:0] {OWN_V, OWN_C, OWN_D} owner_e;

    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/vram_arb_pick.sv
// Combinational winner select: starved c/d ports beat video, otherwise
// video first, then round-robin between c and d.
module vram_arb_pick
    import vram_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic       req_v_i,
    input  logic       req_c_i,
    input  logic       req_d_i,
    input  logic [2:0] wait_c_i,
    input  logic [2:0] wait_d_i,
    input  logic       rr_d_i,
    output logic       valid_o,
    output owner_e     owner_o
);

    logic c_hot, d_hot;

    assign c_hot   = req_c_i && (wait_c_i >= 3'(MAX_WAIT));
    assign d_hot   = req_d_i && (wait_d_i >= 3'(MAX_WAIT));
    assign valid_o = req_v_i | req_c_i | req_d_i;

    always_comb begin
        owner_o = OWN_V;
        if (c_hot && d_hot)             owner_o = rr_d_i ? OWN_D : OWN_C;
        else if (c_hot)                 owner_o = OWN_C;
        else if (d_hot)                 owner_o = OWN_D;
        else if (req_v_i)               owner_o = OWN_V;
        else if (req_c_i && req_d_i)    owner_o = rr_d_i ? OWN_D : OWN_C;
        else if (req_c_i)               owner_o = OWN_C;
        else if (req_d_i)               owner_o = OWN_D;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Three-port (video/CPU/DMA) VRAM arbiter with anti-starvation wait counters
// and a downstream timeout that completes the owner with ABORT_DATA.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_v_request,
    input  logic        i_c_request,
    input  logic        i_d_request,
    input  logic        i_v_rw,
    input  logic        i_c_rw,
    input  logic        i_d_rw,
    input  logic [31:0] i_v_address,
    input  logic [31:0] i_c_address,
    input  logic [31:0] i_d_address,
    input  logic [31:0] i_v_wdata,
    input  logic [31:0] i_c_wdata,
    input  logic [31:0] i_d_wdata,
    output logic [31:0] o_v_rdata,
    output logic [31:0] o_c_rdata,
    output logic [31:0] o_d_rdata,
    output logic        o_v_ready,
    output logic        o_c_ready,
    output logic        o_d_ready,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ready,
    output logic        o_video_busy,
    output logic        o_timeout
);

    state_e            state_q;
    owner_e            owner_q, pick_own;
    logic              pick_vld;
    logic [2:0]        wait_c_q, wait_d_q;
    logic              rr_d_q;
    logic [7:0]        tcnt_q;
    logic              timeout_q;
    logic              bus_req_q, bus_rw_q;
    logic [31:0]       bus_addr_q, bus_wdata_q;
    logic [2:0]        rdy_q;
    logic [2:0][31:0]  rdata_q;

    // Per-port inputs packed so the owner enum can index them directly.
    logic [2:0]        rw_w;
    logic [2:0][31:0]  addr_w, wdata_w;
    logic [31:0]       ack_data;
    logic              tmo_hit;

    assign rw_w     = {i_d_rw, i_c_rw, i_v_rw};
    assign addr_w   = {i_d_address, i_c_address, i_v_address};
    assign wdata_w  = {i_d_wdata, i_c_wdata, i_v_wdata};
    assign tmo_hit  = (tcnt_q == 8'(TIMEOUT));
    assign ack_data = i_bus_ready ? i_bus_rdata : ABORT_DATA;

    vram_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
        .req_v_i  (i_v_request),
        .req_c_i  (i_c_request),
        .req_d_i  (i_d_request),
        .wait_c_i (wait_c_q),
        .wait_d_i (wait_d_q),
        .rr_d_i   (rr_d_q),
        .valid_o  (pick_vld),
        .owner_o  (pick_own)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_V;
            wait_c_q    <= '0;
            wait_d_q    <= '0;
            rr_d_q      <= 1'b0;
            tcnt_q      <= '0;
            timeout_q   <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_rw_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdy_q       <= '0;
            rdata_q     <= '0;
        end else begin
            rdy_q <= '0;
            case (state_q)
                ST_IDLE: if (pick_vld) begin
                    state_q     <= ST_ACTIVE;
                    owner_q     <= pick_own;
                    tcnt_q      <= '0;
                    bus_req_q   <= 1'b1;
                    bus_rw_q    <= rw_w[pick_own];
                    bus_addr_q  <= addr_w[pick_own];
                    bus_wdata_q <= wdata_w[pick_own];
                    wait_c_q    <= (pick_own == OWN_C) ? 3'd0 :
                                   (i_c_request ? sat_inc3(wait_c_q) : wait_c_q);
                    wait_d_q    <= (pick_own == OWN_D) ? 3'd0 :
                                   (i_d_request ? sat_inc3(wait_d_q) : wait_d_q);
                    // Pointer aims at the c/d port that did not just win.
                    if (pick_own != OWN_V) rr_d_q <= (pick_own == OWN_C);
                end
                ST_ACTIVE: if (i_bus_ready || tmo_hit) begin
                    state_q          <= ST_ACK;
                    bus_req_q        <= 1'b0;
                    rdy_q[owner_q]   <= 1'b1;
                    rdata_q[owner_q] <= ack_data;
                    if (!i_bus_ready) timeout_q <= 1'b1;
                end else begin
                    tcnt_q <= tcnt_q + 8'd1;
                end
                ST_ACK:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_bus_request = bus_req_q;
    assign o_bus_rw      = bus_rw_q;
    assign o_bus_address = bus_addr_q;
    assign o_bus_wdata   = bus_wdata_q;
    assign o_v_ready     = rdy_q[0];
    assign o_c_ready     = rdy_q[1];
    assign o_d_ready     = rdy_q[2];
    assign o_v_rdata     = rdata_q[0];
    assign o_c_rdata     = rdata_q[1];
    assign o_d_rdata     = rdata_q[2];
    assign o_timeout     = timeout_q;
    assign o_video_busy  = i_v_request | ((state_q != ST_IDLE) && (owner_q == OWN_V));

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a table of arbitration rounds plus
// hand-written sequences for latency, timeout, video busy and reset.
module tb_vram_arbiter;

    localparam logic [31:0] V_ADDR = 32'h0000_0010, C_ADDR = 32'h0000_0100, D_ADDR = 32'h0000_0200;
    localparam logic [31:0] V_WD   = 32'hA5A5_0001, C_WD   = 32'hC3C3_0002, D_WD   = 32'hD7D7_0003;

    logic        i_clock = 1'b0, i_reset_n = 1'b0;
    logic        i_v_request = 1'b0, i_c_request = 1'b0, i_d_request = 1'b0;
    logic        i_v_rw = 1'b0, i_c_rw = 1'b0, i_d_rw = 1'b1;
    logic [31:0] i_v_address = V_ADDR, i_c_address = C_ADDR, i_d_address = D_ADDR;
    logic [31:0] i_v_wdata = V_WD, i_c_wdata = C_WD, i_d_wdata = D_WD;
    logic [31:0] o_v_rdata, o_c_rdata, o_d_rdata;
    logic        o_v_ready, o_c_ready, o_d_ready;
    logic        o_bus_request, o_bus_rw, o_video_busy, o_timeout;
    logic [31:0] o_bus_address, o_bus_wdata;
    logic [31:0] i_bus_rdata;
    logic        i_bus_ready;

    // Auto responder (ready resp_lat cycles after request) or manual drive.
    logic        resp_en = 1'b0, resp_rdy = 1'b0, man_rdy = 1'b0;
    logic [31:0] resp_data = '0, man_data = '0;
    int          resp_lat = 1;
    assign i_bus_ready = resp_en ? resp_rdy : man_rdy;
    assign i_bus_rdata = resp_en ? resp_data : man_data;

    int checks = 0, fails = 0;

    vram_arbiter #(.MAX_WAIT(4), .TIMEOUT(8)) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n),
        .i_v_request(i_v_request), .i_c_request(i_c_request), .i_d_request(i_d_request),
        .i_v_rw(i_v_rw), .i_c_rw(i_c_rw), .i_d_rw(i_d_rw),
        .i_v_address(i_v_address), .i_c_address(i_c_address), .i_d_address(i_d_address),
        .i_v_wdata(i_v_wdata), .i_c_wdata(i_c_wdata), .i_d_wdata(i_d_wdata),
        .o_v_rdata(o_v_rdata), .o_c_rdata(o_c_rdata), .o_d_rdata(o_d_rdata),
        .o_v_ready(o_v_ready), .o_c_ready(o_c_ready), .o_d_ready(o_d_ready),
        .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw),
        .o_bus_address(o_bus_address), .o_bus_wdata(o_bus_wdata),
        .i_bus_rdata(i_bus_rdata), .i_bus_ready(i_bus_ready),
        .o_video_busy(o_video_busy), .o_timeout(o_timeout)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [2:0]  req;      // {v,c,d}
        logic [2:0]  exp_rdy;  // {v,c,d} one-hot winner
        logic [31:0] rdata;    // downstream data returned this round
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] m);
        i_v_request = m[2]; i_c_request = m[1]; i_d_request = m[0];
    endtask

    task automatic wait_bus();
        int n = 0;
        do begin @(negedge i_clock); n++; end while (!o_bus_request && n < 10);
    endtask

    task automatic wait_rdy();
        int n = 0;
        do begin @(negedge i_clock); n++; end
        while (!(o_v_ready | o_c_ready | o_d_ready) && n < 30);
    endtask

    function automatic logic [31:0] sel_rdata(input logic [2:0] e);
        return e[2] ? o_v_rdata : (e[1] ? o_c_rdata : o_d_rdata);
    endfunction

    function automatic logic [31:0] port_addr(input logic [2:0] e);
        return e[2] ? V_ADDR : (e[1] ? C_ADDR : D_ADDR);
    endfunction

    function automatic logic [31:0] port_wd(input logic [2:0] e);
        return e[2] ? V_WD : (e[1] ? C_WD : D_WD);
    endfunction

    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(negedge i_clock);
            if (resp_en && o_bus_request) begin
                resp_rdy = (cnt == resp_lat);
                cnt++;
            end else begin
                resp_rdy = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int k;
        // v+c: c starves 4 rounds then wins; d alone; c/d alternate; all three.
        tbl[0]  = '{3'b110, 3'b100, 32'h1000_0001};
        tbl[1]  = '{3'b110, 3'b100, 32'h1000_0002};
        tbl[2]  = '{3'b110, 3'b100, 32'h1000_0003};
        tbl[3]  = '{3'b110, 3'b100, 32'h1000_0004};
        tbl[4]  = '{3'b110, 3'b010, 32'h1000_0005};
        tbl[5]  = '{3'b001, 3'b001, 32'h1000_0006};
        tbl[6]  = '{3'b011, 3'b010, 32'h1000_0007};
        tbl[7]  = '{3'b011, 3'b001, 32'h1000_0008};
        tbl[8]  = '{3'b011, 3'b010, 32'h1000_0009};
        tbl[9]  = '{3'b011, 3'b001, 32'h1000_000A};
        tbl[10] = '{3'b111, 3'b100, 32'h1000_000B};
        tbl[11] = '{3'b111, 3'b100, 32'h1000_000C};
        tbl[12] = '{3'b111, 3'b100, 32'h1000_000D};
        tbl[13] = '{3'b111, 3'b010, 32'h1000_000E};
        tbl[14] = '{3'b111, 3'b001, 32'h1000_000F};
        tbl[15] = '{3'b111, 3'b100, 32'h1000_0010};
        tbl[16] = '{3'b111, 3'b100, 32'h1000_0011};
        tbl[17] = '{3'b111, 3'b100, 32'h1000_0012};
        tbl[18] = '{3'b111, 3'b010, 32'h1000_0013};
        tbl[19] = '{3'b111, 3'b001, 32'h1000_0014};

        repeat (2) @(negedge i_clock);
        chk("rst_bus_req", o_bus_request, 1'b0);
        chk("rst_ready", {o_v_ready, o_c_ready, o_d_ready}, 3'b000);
        chk("rst_v_rdata", o_v_rdata, 32'h0);
        chk("rst_timeout", o_timeout, 1'b0);
        chk("rst_vbusy", o_video_busy, 1'b0);
        i_reset_n = 1'b1;

        resp_en = 1'b1; resp_lat = 1;
        for (int i = 0; i < 20; i++) begin
            set_req(tbl[i].req);
            resp_data = tbl[i].rdata;
            wait_bus();
            chk($sformatf("r%0d_bus_req", i), o_bus_request, 1'b1);
            chk($sformatf("r%0d_bus_addr", i), o_bus_address, port_addr(tbl[i].exp_rdy));
            chk($sformatf("r%0d_bus_rw", i), o_bus_rw, tbl[i].exp_rdy[0]);
            chk($sformatf("r%0d_bus_wdata", i), o_bus_wdata, port_wd(tbl[i].exp_rdy));
            wait_rdy();
            chk($sformatf("r%0d_ready", i), {o_v_ready, o_c_ready, o_d_ready}, tbl[i].exp_rdy);
            chk($sformatf("r%0d_rdata", i), sel_rdata(tbl[i].exp_rdy), tbl[i].rdata);
        end
        chk("hold_v_rdata", o_v_rdata, 32'h1000_0012);
        chk("hold_c_rdata", o_c_rdata, 32'h1000_0013);

        // Downstream ready while idle must not complete anything.
        set_req(3'b000); resp_en = 1'b0; man_rdy = 1'b1;
        repeat (2) begin
            @(negedge i_clock);
            chk("idle_ready_ign", {o_v_ready, o_c_ready, o_d_ready, o_bus_request}, 4'b0000);
        end

        // CPU read latency: ready sampled at edge M -> o_c_ready only in cycle M+1.
        man_rdy = 1'b0; i_c_request = 1'b1;
        @(negedge i_clock);
        chk("cpu_bus_req", o_bus_request, 1'b1);
        chk("cpu_bus_addr", o_bus_address, 32'h100);
        chk("cpu_bus_rw", o_bus_rw, 1'b0);
        man_rdy = 1'b1; man_data = 32'h1234_5678;
        @(negedge i_clock);
        chk("cpu_ready", {o_v_ready, o_c_ready, o_d_ready}, 3'b010);
        chk("cpu_rdata", o_c_rdata, 32'h1234_5678);
        chk("cpu_bus_drop", o_bus_request, 1'b0);
        man_rdy = 1'b0; i_c_request = 1'b0;
        @(negedge i_clock);
        chk("cpu_ready_1cyc", o_c_ready, 1'b0);

        // Timeout=8: abort pulse 9 cycles after o_bus_request; request dropped mid-flight.
        @(negedge i_clock);
        i_d_request = 1'b1;
        wait_bus();
        chk("tmo_bus_addr", o_bus_address, D_ADDR);
        chk("tmo_timeout_pre", o_timeout, 1'b0);
        k = 0;
        while (!o_d_ready && k < 20) begin
            @(negedge i_clock);
            k++;
            if (k == 2) i_d_request = 1'b0;
        end
        chk("tmo_latency", k, 9);
        chk("tmo_rdata", o_d_rdata, 32'hDEAD_BEEF);
        chk("tmo_flag", o_timeout, 1'b1);
        chk("tmo_bus_drop", o_bus_request, 1'b0);
        repeat (2) @(negedge i_clock);
        chk("tmo_sticky", o_timeout, 1'b1);
        chk("tmo_no_regrant", o_bus_request, 1'b0);

        // Video request during a DMA transaction: busy at once, DMA finishes first.
        resp_en = 1'b1; resp_lat = 3; resp_data = 32'h0D0D_0D0D;
        i_d_request = 1'b1;
        wait_bus();
        chk("vb_owner_d", o_bus_address, D_ADDR);
        chk("vb_busy_pre", o_video_busy, 1'b0);
        i_v_request = 1'b1;
        #1;
        chk("vb_busy_now", o_video_busy, 1'b1);
        wait_rdy();
        chk("vb_d_first", {o_v_ready, o_c_ready, o_d_ready}, 3'b001);
        chk("vb_d_rdata", o_d_rdata, 32'h0D0D_0D0D);
        i_d_request = 1'b0; resp_data = 32'h0E0E_0E0E;
        wait_bus();
        chk("vb_v_next", o_bus_address, V_ADDR);
        wait_rdy();
        chk("vb_v_ready", {o_v_ready, o_c_ready, o_d_ready}, 3'b100);
        chk("vb_v_rdata", o_v_rdata, 32'h0E0E_0E0E);
        i_v_request = 1'b0;

        // Reset mid-ACTIVE: bus request drops immediately, v regranted on first edge.
        resp_en = 1'b0; man_rdy = 1'b0;
        @(negedge i_clock);
        i_v_request = 1'b1;
        wait_bus();
        chk("rr_active", o_bus_request, 1'b1);
        #2 i_reset_n = 1'b0;
        #1;
        chk("rr_bus_req", o_bus_request, 1'b0);
        chk("rr_timeout", o_timeout, 1'b0);
        chk("rr_v_rdata", o_v_rdata, 32'h0);
        @(negedge i_clock);
        i_reset_n = 1'b1;
        @(negedge i_clock);
        chk("rr_regrant", o_bus_request, 1'b1);
        chk("rr_regrant_addr", o_bus_address, V_ADDR);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
